serial_addsub: RTL
==================

# serial_addsub

Parametrised bit-serial two's-complement adder/subtractor with a start/busy/done handshake. It captures two WIDTH-bit operands on an accepted start and processes one bit per clock, LSB first, through a single full-adder cell. It then presents a registered WIDTH-bit result with carry-out and signed overflow. It succeeds the fixed 8-bit, reset-loaded serial adder in the arithmetic datapath and frees callers from counting cycles themselves.

## Interface
- WIDTH, 8: operand/result width in bits; legal range 2..64
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE or DONE
- sub  in  1  0 = A+B, 1 = A−B; captured with operands
- data_a  in  WIDTH  operand A; captured on accepted start
- data_b  in  WIDTH  operand B; captured on accepted start
- busy  out  1  high while bits are being processed
- done  out  1  one-cycle completion pulse
- sum  out  WIDTH  registered result
- cout  out  1  final carry (add: unsigned carry; sub: 1 = no borrow)
- ovf  out  1  signed overflow

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - load shift_a←data_a, shift_b←data_b (or ~data_b if sub), carry←sub, bit counter←0
  - go to SHIFT
- SHIFT, each cycle:
  - s = a0^b0^c; c' = majority(a0,b0,c)
  - shift A and B right; shift s into the MSB of the partial register; count +1
  - record the carry into the MSB (the carry before the last bit) for overflow
- After the WIDTH-th bit:
  - sum←partial; cout←c'; ovf←carry_into_msb ^ c'
  - go to DONE
- DONE:
  - done=1 for exactly one cycle
  - start=1 here is accepted as in IDLE (back-to-back); otherwise go to IDLE
- start while in SHIFT is ignored; operands and sub are not re-sampled.
- sum/cout/ovf change only at completion and hold until the next completion. The partial register is internal.
- Bit counter width is $clog2(WIDTH+1). Arithmetic is modulo 2^WIDTH.

## Timing
- Reset, asynchronous: state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0; internal registers 0.
- Start accepted at edge E0: busy=1 from E0 until edge E_WIDTH.
- At edge E_WIDTH: results are valid, busy=0 and done=1. done drops at E_WIDTH+1.
- Latency from accepted start to done is WIDTH cycles. Back-to-back throughput is one operation per WIDTH+1 cycles.
- Reset asserted mid-SHIFT aborts the operation: no done pulse, outputs return to 0.
- start held high continuously gives repeated operations, each re-capturing operands in the DONE cycle.

## Configuration
- SERIAL_ADDSUB_SUB_EN defined: subtraction is supported as described.
- Not defined:
  - the sub port remains but is ignored; always A+B with initial carry 0
  - operand B is never inverted
  - cout and ovf keep their add meanings

## Structure
- Shared package serial_pkg:
  - state enum (IDLE, SHIFT, DONE)
  - WIDTH range-check constants
- One sub-module: serial_fa_cell, a 1-bit full adder (a, b, cin → s, cout), instantiated once.
- Top level holds the FSM, shift registers, counter and output registers.

## Test plan
- WIDTH=8, add, 0x22+0x0A → sum=0x2C, cout=0, ovf=0; done exactly 8 cycles after the start edge; busy high for 8 cycles.
- Add 0xFF+0x01 → sum=0x00, cout=1, ovf=0. Add 0x7F+0x01 → sum=0x80, cout=0, ovf=1.
- With SERIAL_ADDSUB_SUB_EN:
  - sub 0x14−0x15 → sum=0xFF, cout=0, ovf=0
  - sub 0x80−0x01 → sum=0x7F, cout=1, ovf=1
  - without the macro, sub=1 on 0x14,0x15 → sum=0x29
- Mid-op behaviour:
  - start pulsed again mid-SHIFT with different operands → ignored; original result reported
  - reset asserted at cycle 4 of SHIFT → outputs 0, no done pulse
  - a new start after reset completes normally
- start held high with 0x14+0x15 then 0x22+0x0A presented in the DONE cycle → sums 0x29 then 0x2C, done pulses 9 cycles apart; repeat with WIDTH=16, 0xFFFF+0x0001 → 0x0000, cout=1.

Source files
------------

// File: rtl/serial_pkg.sv
// serial_pkg: shared definitions for the bit-serial adder/subtractor.
// Holds the controller state encoding and the legal WIDTH range.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_fa_cell.sv
// serial_fa_cell: single 1-bit full adder, the only arithmetic element of the
// serial datapath.
module serial_fa_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);

    // Sum and majority carry.
    always_comb begin
        o_s    = i_a ^ i_b ^ i_cin;
        o_cout = (i_a & i_b) | (i_a & i_cin) | (i_b & i_cin);
    end

endmodule

// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial two's-complement adder/subtractor, one bit per
// clock, LSB first, with start/busy/done handshake.
// Optional feature macro: SERIAL_ADDSUB_SUB_EN (enables subtraction via sub).
//
// Handshake: start is sampled only while idle or in the done cycle; an
// accepted start raises busy on the same edge, busy stays high for WIDTH
// cycles, and done pulses for one cycle together with valid sum/cout/ovf.
// start while busy is ignored. sum/cout/ovf hold until the next completion.
module serial_addsub
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("serial_addsub: WIDTH out of range 2..64");
    end

    state_t             r_state;
    state_t             w_next_state;
    logic               w_load;
    logic               w_last;

    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-2:0]   r_partial;
    logic               r_carry;
    logic [CW-1:0]      r_cnt;

    logic [WIDTH-1:0]   w_b_load;
    logic               w_cin_load;
    logic               w_s;
    logic               w_c;
    logic [WIDTH-1:0]   w_partial_next;

`ifdef SERIAL_ADDSUB_SUB_EN
    // Subtraction is A + ~B + 1: invert B at capture and seed the carry.
    assign w_b_load   = sub ? ~data_b : data_b;
    assign w_cin_load = sub;
`else
    // Addition only: sub is accepted on the port but has no effect.
    logic w_unused_sub;
    assign w_b_load     = data_b;
    assign w_cin_load   = 1'b0;
    assign w_unused_sub = sub;
`endif

    serial_fa_cell u_fa (
        .i_a    (r_a[0]),
        .i_b    (r_b[0]),
        .i_cin  (r_carry),
        .o_s    (w_s),
        .o_cout (w_c)
    );

    // New sum bit enters at the MSB; after WIDTH bits this is the full result.
    assign w_partial_next = {w_s, r_partial};
    assign dbg_state      = r_state;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        w_load       = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                busy = 1'b1;
                if (r_cnt == LAST_BIT) begin
                    w_last       = 1'b1;
                    w_next_state = DONE;
                end
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    w_load       = 1'b1;
                    w_next_state = SHIFT;
                end else begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Operand capture and one-bit-per-cycle shifting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a       <= '0;
            r_b       <= '0;
            r_partial <= '0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
        end else if (w_load) begin
            r_a       <= data_a;
            r_b       <= w_b_load;
            r_partial <= '0;
            r_carry   <= w_cin_load;
            r_cnt     <= '0;
        end else if (r_state == SHIFT) begin
            r_a       <= r_a >> 1;
            r_b       <= r_b >> 1;
            r_partial <= w_partial_next[WIDTH-1:1];
            r_carry   <= w_c;
            r_cnt     <= r_cnt + CW'(1);
        end
    end

    // Result registers; on the last bit r_carry is the carry into the MSB,
    // so its XOR with the carry out is the signed overflow.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum  <= '0;
            cout <= 1'b0;
            ovf  <= 1'b0;
        end else if (w_last) begin
            sum  <= w_partial_next;
            cout <= w_c;
            ovf  <= r_carry ^ w_c;
        end
    end

endmodule
